// File: rtl/sha256_padder_pkg.sv
// Shared definitions for the SHA-256 padder and core: FSM states, padding
// constants and the SHA-256 initial hash / round constant tables.
package sha256_padder_pkg;

    typedef enum logic [1:0] {
        S_FILL     = 2'd0,
        S_EMIT     = 2'd1,
        S_EMIT_PAD = 2'd2
    } state_t;

    localparam logic [7:0] PAD_BYTE    = 8'h80;
    localparam int         BLOCK_BYTES = 64;
    localparam int         LEN_POS     = 56;

    localparam logic [255:0] SHA_H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:63][31:0] SHA_K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_padder.sv
// Byte-stream to SHA-256 padded 512-bit block converter with a valid/ready
// block output; emits an extra pad-only block when the tail does not fit.
module sha256_padder
    import sha256_padder_pkg::*;
#(
    parameter int LEN_W = 61
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   msg_byte,
    input  logic         msg_valid,
    input  logic         msg_last,
    output logic         msg_ready,
    output logic [511:0] block_data,
    output logic         block_valid,
    output logic         block_last,
    input  logic         block_ready
);

    state_t            state_reg, state_next;
    logic [5:0]        ptr_reg;
    logic [LEN_W-1:0]  count_reg;
    logic [LEN_W-1:0]  count_inc;
    logic [0:63][7:0]  buf_reg;
    logic [0:63][7:0]  byte_next;
    logic [0:63]       byte_we;
    logic              last_reg, pad_pending_reg, pad_mark_reg;
    logic              accept, handshake;
    logic [63:0]       len_inc, len_cur;

    assign accept    = msg_valid & msg_ready;
    assign handshake = block_valid & block_ready;
    assign count_inc = count_reg + {{(LEN_W-1){1'b0}}, 1'b1};
    assign len_inc   = 64'({count_inc, 3'b000});
    assign len_cur   = 64'({count_reg, 3'b000});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= S_FILL;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        msg_ready   = 1'b0;
        block_valid = 1'b0;
        block_last  = 1'b0;
        block_data  = buf_reg;
        case (state_reg)
            S_FILL: begin
                msg_ready = 1'b1;
                if (msg_valid && (msg_last || ptr_reg == 6'd63))
                    state_next = S_EMIT;
            end
            S_EMIT: begin
                block_valid = 1'b1;
                block_last  = last_reg;
                if (block_ready)
                    state_next = pad_pending_reg ? S_EMIT_PAD : S_FILL;
            end
            S_EMIT_PAD: begin
                block_valid = 1'b1;
                block_last  = 1'b1;
                block_data  = {(pad_mark_reg ? PAD_BYTE : 8'h00), 440'd0, len_cur};
                if (block_ready)
                    state_next = S_FILL;
            end
            default: state_next = S_FILL;
        endcase
    end

    // Tail classification is captured with the final byte so the emit states
    // never need to look back at the pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg         <= 6'd0;
            count_reg       <= '0;
            last_reg        <= 1'b0;
            pad_pending_reg <= 1'b0;
            pad_mark_reg    <= 1'b0;
        end else if (accept) begin
            ptr_reg         <= ptr_reg + 6'd1;
            count_reg       <= count_inc;
            last_reg        <= msg_last && (ptr_reg <= 6'd54);
            pad_pending_reg <= msg_last && (ptr_reg >= 6'd55);
            pad_mark_reg    <= msg_last && (ptr_reg == 6'd63);
        end else if (handshake) begin
            ptr_reg <= 6'd0;
            if (state_reg == S_EMIT_PAD || (!pad_pending_reg && last_reg))
                count_reg <= '0;
        end
    end

    // Per-byte write decoder: data at ptr, 0x80 right after a final byte,
    // and zeros or length bytes beyond it so no stale data survives.
    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_BYTES; gi++) begin : g_byte
            logic [7:0] len_byte;
            logic       is_data, is_after, is_pad;
            if (gi >= LEN_POS) begin : g_len
                assign len_byte = (ptr_reg <= 6'd54) ? len_inc[(63-gi)*8 +: 8] : 8'h00;
            end else begin : g_nolen
                assign len_byte = 8'h00;
            end
            assign is_data      = (ptr_reg == 6'(gi));
            assign is_after     = msg_last && (7'(gi) > {1'b0, ptr_reg});
            assign is_pad       = msg_last && (7'(gi) == {1'b0, ptr_reg} + 7'd1);
            assign byte_we[gi]  = accept && (is_data || is_after);
            assign byte_next[gi] = is_data ? msg_byte : (is_pad ? PAD_BYTE : len_byte);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_reg <= '0;
        end else begin
            for (int i = 0; i < BLOCK_BYTES; i++)
                if (byte_we[i]) buf_reg[i] <= byte_next[i];
        end
    end

endmodule
